// File: rtl/memlcd_line_ctrl_if.sv
// rtl/memlcd_line_ctrl_if.sv - FIFO read-side bundle between the sync FIFO and the line controller
interface memlcd_line_ctrl_if;
    logic [7:0] i_data;
    logic       i_rempty;
    logic       o_rinc;

    modport master (output i_data, output i_rempty, input o_rinc);
    modport slave  (input i_data, input i_rempty, output o_rinc);
endinterface

// File: rtl/memlcd_line_ctrl.sv
// rtl/memlcd_line_ctrl.sv - memory-LCD line controller: packet parse, gate seek, source load, VCOM
module memlcd_line_ctrl #(
    parameter int H_PIXELS   = 72,
    parameter int V_LINES    = 144,
    parameter int BCK_HALF   = 4,
    parameter int GCK_HALF   = 8,
    parameter int GEN_CYCLES = 16,
    parameter int VCOM_DIV   = 833333,
    parameter int VCOM_SYNC  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    memlcd_line_ctrl_if.slave  fifo,
    output logic               o_intb,
    output logic               o_gsp,
    output logic               o_gck,
    output logic               o_gen,
    output logic               o_bsp,
    output logic               o_bck,
    output logic [5:0]         o_rgb,
    output logic               o_vcom,
    output logic               o_va,
    output logic               o_vb,
    output logic               o_busy,
    output logic [7:0]         o_line,
    output logic               o_drop
);
    localparam int BPL   = H_PIXELS / 2;
    localparam int T_AB  = (BCK_HALF > GCK_HALF) ? BCK_HALF : GCK_HALF;
    localparam int T_MAX = (T_AB > GEN_CYCLES) ? T_AB : GEN_CYCLES;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int BC_W  = $clog2(BPL + 1);
    localparam int VC_W  = (VCOM_DIV > 1) ? $clog2(VCOM_DIV) : 1;
    localparam logic [7:0] V_LIM = 8'(V_LINES);

    typedef enum logic [2:0] {
        S_IDLE, S_DROP, S_GSTART, S_SEEK, S_LOAD, S_WRITE
    } state_t;

    // LOAD sub-phases: wait for a byte, hold it for a BCK half-period, park BCK low after an odd count
    typedef enum logic [1:0] {
        L_WAIT, L_HOLD, L_PARK
    } lphase_t;

    state_t            state_q, state_d;
    lphase_t           lph_q, lph_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        line_q, line_d;
    logic              gvalid_q, gvalid_d;
    logic              gsp_q, gsp_d;
    logic              gck_q, gck_d;
    logic              gen_q, gen_d;
    logic              bsp_q, bsp_d;
    logic              bck_q, bck_d;
    logic [5:0]        rgb_q, rgb_d;
    logic              drop_q, drop_d;
    logic              intb_q, intb_d;
    logic              rinc_q, rinc_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic              vcom_q, vcom_d;
    logic              vpend_q, vpend_d;

    logic pop;
    logic can_pop;
    logic go_load;
    logic go_write;
    logic vcnt_wrap;

    // FSM next-state: packet parsing, gate positioning, source shifting and GEN pulse
    always_comb begin
        state_d  = state_q;
        lph_d    = lph_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        addr_d   = addr_q;
        line_d   = line_q;
        gvalid_d = gvalid_q;
        gsp_d    = gsp_q;
        gck_d    = gck_q;
        gen_d    = gen_q;
        bsp_d    = bsp_q;
        bck_d    = bck_q;
        rgb_d    = rgb_q;
        drop_d   = 1'b0;
        intb_d   = 1'b1;
        pop      = 1'b0;
        go_load  = 1'b0;
        go_write = 1'b0;
        // a pop needs data present and no pop on the previous cycle; nothing is consumed under reset
        can_pop  = !fifo.i_rempty && !rinc_q && !i_reset;

        case (state_q)
            S_IDLE: begin
                if (can_pop) begin
                    pop    = 1'b1;
                    addr_d = fifo.i_data;
                    if (fifo.i_data >= V_LIM) begin
                        state_d = S_DROP;
                        drop_d  = 1'b1;
                        bcnt_d  = '0;
                    end else if (!gvalid_q || fifo.i_data < line_q) begin
                        state_d  = S_GSTART;
                        gck_d    = 1'b0;
                        gsp_d    = 1'b1;
                        line_d   = 8'd0;
                        gvalid_d = 1'b1;
                        cnt_d    = '0;
                    end else if (fifo.i_data == line_q) begin
                        go_load = 1'b1;
                    end else begin
                        state_d = S_SEEK;
                        cnt_d   = '0;
                    end
                end
            end
            S_DROP: begin
                if (can_pop) begin
                    pop    = 1'b1;
                    bcnt_d = bcnt_q + BC_W'(1);
                    if (bcnt_q == BC_W'(BPL - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GSTART: begin
                if (cnt_q == CNT_W'(GCK_HALF - 1)) begin
                    gsp_d = 1'b0;
                    cnt_d = '0;
                    if (addr_q == 8'd0) begin
                        go_load = 1'b1;
                    end else begin
                        state_d = S_SEEK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEEK: begin
                if (cnt_q == CNT_W'(GCK_HALF - 1)) begin
                    cnt_d = '0;
                    gck_d = ~gck_q;
                    // the gate advances on the rising GCK edge; leave for LOAD on the same edge
                    if (!gck_q) begin
                        line_d = line_q + 8'd1;
                        if (line_q + 8'd1 == addr_q) begin
                            go_load = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD: begin
                case (lph_q)
                    L_WAIT: begin
                        if (can_pop) begin
                            pop   = 1'b1;
                            rgb_d = fifo.i_data[5:0];
                            cnt_d = '0;
                            lph_d = L_HOLD;
                        end
                    end
                    L_HOLD: begin
                        // the pop cycle counts toward the hold, so BCK toggles BCK_HALF cycles after it
                        if (cnt_q == CNT_W'(BCK_HALF - 2)) begin
                            bck_d  = ~bck_q;
                            bsp_d  = 1'b0;
                            bcnt_d = bcnt_q + BC_W'(1);
                            if (bcnt_q == BC_W'(BPL - 1)) begin
                                if (bck_q) begin
                                    go_write = 1'b1;
                                end else begin
                                    lph_d = L_PARK;
                                end
                            end else begin
                                lph_d = L_WAIT;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    L_PARK: begin
                        bck_d    = 1'b0;
                        go_write = 1'b1;
                    end
                    default: lph_d = L_WAIT;
                endcase
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(GEN_CYCLES - 1)) begin
                    gen_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_load) begin
            state_d = S_LOAD;
            lph_d   = L_WAIT;
            bcnt_d  = '0;
            bsp_d   = 1'b1;
            cnt_d   = '0;
        end
        if (go_write) begin
            state_d = S_WRITE;
            gen_d   = 1'b1;
            cnt_d   = '0;
        end
        rinc_d = pop;
    end

    // VCOM divider; a wrap that meets GEN high is held until the edge where GEN drops
    always_comb begin
        vcnt_wrap = (vcnt_q == VC_W'(VCOM_DIV - 1));
        vcnt_d    = vcnt_wrap ? '0 : vcnt_q + VC_W'(1);
        vcom_d    = vcom_q;
        vpend_d   = vpend_q;
        if (vcnt_wrap) begin
            if (VCOM_SYNC != 0 && gen_d) begin
                vpend_d = 1'b1;
            end else begin
                vcom_d = ~vcom_q;
            end
        end else if (vpend_q && !gen_d) begin
            vcom_d  = ~vcom_q;
            vpend_d = 1'b0;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            lph_q    <= L_WAIT;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            gvalid_q <= 1'b0;
            gsp_q    <= 1'b0;
            gck_q    <= 1'b0;
            gen_q    <= 1'b0;
            bsp_q    <= 1'b0;
            bck_q    <= 1'b0;
            rgb_q    <= '0;
            drop_q   <= 1'b0;
            intb_q   <= 1'b0;
            rinc_q   <= 1'b0;
            vcnt_q   <= '0;
            vcom_q   <= 1'b0;
            vpend_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lph_q    <= lph_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            gvalid_q <= gvalid_d;
            gsp_q    <= gsp_d;
            gck_q    <= gck_d;
            gen_q    <= gen_d;
            bsp_q    <= bsp_d;
            bck_q    <= bck_d;
            rgb_q    <= rgb_d;
            drop_q   <= drop_d;
            intb_q   <= intb_d;
            rinc_q   <= rinc_d;
            vcnt_q   <= vcnt_d;
            vcom_q   <= vcom_d;
            vpend_q  <= vpend_d;
        end
    end

    assign fifo.o_rinc = pop;
    assign o_intb      = intb_q;
    assign o_gsp       = gsp_q;
    assign o_gck       = gck_q;
    assign o_gen       = gen_q;
    assign o_bsp       = bsp_q;
    assign o_bck       = bck_q;
    assign o_rgb       = rgb_q;
    assign o_vcom      = vcom_q;
    assign o_va        = ~vcom_q;
    assign o_vb        = vcom_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_line      = line_q;
    assign o_drop      = drop_q;
endmodule

// File: tb/tb_memlcd_line_ctrl.sv
// tb/tb_memlcd_line_ctrl.sv - randomized self-checking bench for memlcd_line_ctrl
module tb_memlcd_line_ctrl;
    localparam int VDIV = 20;
    localparam int BPL  = 36;
    localparam int VL   = 144;
    localparam int GH   = 8;
    localparam int GENC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memlcd_line_ctrl_if fifo_if ();
    logic       o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck;
    logic [5:0] o_rgb;
    logic       o_vcom, o_va, o_vb, o_busy, o_drop;
    logic [7:0] o_line;

    memlcd_line_ctrl #(.VCOM_DIV(VDIV), .VCOM_SYNC(1)) dut (
        .i_clk(clk), .i_reset(rst), .fifo(fifo_if.slave),
        .o_intb(o_intb), .o_gsp(o_gsp), .o_gck(o_gck), .o_gen(o_gen),
        .o_bsp(o_bsp), .o_bck(o_bck), .o_rgb(o_rgb), .o_vcom(o_vcom),
        .o_va(o_va), .o_vb(o_vb), .o_busy(o_busy), .o_line(o_line), .o_drop(o_drop)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    int pops, gsp_cyc, gck_rise, gck_chg, bck_tog, gen_cyc, gen_rise, bsp_rise, drop_cyc;
    int rinc_empty, rinc_consec, defer_hits;
    logic [5:0] rgb_seen[$];

    // reference state: gate position as the packet rules dictate, VCOM as divider rules dictate
    bit         m_valid = 0;
    int         m_line = 0;
    int         m_cnt = 0;
    bit         m_vcom = 0;
    bit         m_pend = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic clear_stats();
        pops = 0; gsp_cyc = 0; gck_rise = 0; gck_chg = 0; bck_tog = 0; gen_cyc = 0;
        gen_rise = 0; bsp_rise = 0; drop_cyc = 0; rinc_empty = 0; rinc_consec = 0;
        rgb_seen.delete();
    endtask

    // FIFO model (first-word-fall-through) plus cycle monitor and VCOM reference
    initial begin
        bit pop_pend, prev_rinc, rst_s;
        logic prev_gck, prev_bck, prev_gen, prev_bsp;
        prev_rinc = 0; rst_s = 1;
        prev_gck = 0; prev_bck = 0; prev_gen = 0; prev_bsp = 0;
        fifo_if.i_data = 8'h00;
        fifo_if.i_rempty = 1'b1;
        forever begin
            @(negedge clk);
            pop_pend = fifo_if.o_rinc;
            if (fifo_if.o_rinc && fifo_if.i_rempty) rinc_empty++;
            if (fifo_if.o_rinc && prev_rinc) rinc_consec++;
            prev_rinc = fifo_if.o_rinc;
            if (o_gsp) gsp_cyc++;
            if (o_gck !== prev_gck) gck_chg++;
            if (o_gck && !prev_gck) gck_rise++;
            if (o_bck !== prev_bck) begin
                bck_tog++;
                rgb_seen.push_back(o_rgb);
            end
            if (o_gen) gen_cyc++;
            if (o_gen && !prev_gen) gen_rise++;
            if (o_bsp && !prev_bsp) bsp_rise++;
            if (o_drop) drop_cyc++;
            prev_gck = o_gck; prev_bck = o_bck; prev_gen = o_gen; prev_bsp = o_bsp;
            if (rst_s) begin
                m_cnt = 0; m_vcom = 0; m_pend = 0;
            end else begin
                m_cnt = (m_cnt + 1) % VDIV;
                if (m_cnt == 0) begin
                    m_pend = 1;
                    if (o_gen) defer_hits++;
                end
                if (m_pend && !o_gen) begin
                    m_vcom = ~m_vcom;
                    m_pend = 0;
                end
            end
            checks++;
            assert (o_vcom === m_vcom) else begin
                errors++;
                $error("FAIL vcom observed=%0d expected=%0d", o_vcom, m_vcom);
            end
            checks++;
            assert (o_va === ~m_vcom && o_vb === m_vcom) else begin
                errors++;
                $error("FAIL va_vb observed=%0d%0d expected=%0d%0d", o_va, o_vb, ~m_vcom, m_vcom);
            end
            @(posedge clk);
            rst_s = rst;
            #1;
            if (pop_pend) begin
                if (fq.size() > 0) void'(fq.pop_front());
                pops++;
            end
            fifo_if.i_data   = (fq.size() > 0) ? fq[0] : 8'h00;
            fifo_if.i_rempty = (fq.size() == 0);
        end
    end

    task automatic run_packet(input int addr, input int fill, input bit stall);
        logic [7:0] px[$];
        int exp_gsp, exp_rise, exp_bck, exp_gen, exp_drop, exp_ln, bad, guard;
        logic snap_bck;
        logic [5:0] snap_rgb;
        int snap_tog;
        for (int i = 0; i < BPL; i++) px.push_back((fill < 0) ? 8'($urandom) : 8'(fill));
        if (addr >= VL) begin
            exp_drop = 1; exp_gsp = 0; exp_rise = 0; exp_bck = 0; exp_gen = 0; exp_ln = m_line;
        end else begin
            exp_drop = 0; exp_bck = BPL; exp_gen = GENC;
            if (!m_valid || addr < m_line) begin
                exp_gsp = GH; exp_rise = addr;
            end else begin
                exp_gsp = 0; exp_rise = addr - m_line;
            end
            exp_ln = addr; m_valid = 1; m_line = addr;
        end
        clear_stats();
        fq.push_back(8'(addr));
        if (stall) begin
            for (int i = 0; i < 10; i++) fq.push_back(px[i]);
            guard = 0;
            while (pops < 11 && guard < 6000) begin tick(1); guard++; end
            chk("stall_reach", guard < 6000, 1);
            tick(6);
            snap_bck = o_bck; snap_rgb = o_rgb; snap_tog = bck_tog;
            tick(44);
            chk("stall_bck_frozen", {o_bck, 6'(bck_tog - snap_tog)}, {snap_bck, 6'd0});
            chk("stall_rgb_frozen", o_rgb, snap_rgb);
            chk("stall_pops", pops, 11);
            for (int i = 10; i < BPL; i++) fq.push_back(px[i]);
        end else begin
            for (int i = 0; i < BPL; i++) fq.push_back(px[i]);
        end
        guard = 0;
        while (!(pops == BPL + 1 && !o_busy) && guard < 6000) begin tick(1); guard++; end
        chk($sformatf("done_a%0d", addr), guard < 6000, 1);
        chk("pops", pops, BPL + 1);
        chk("drop_pulse", drop_cyc, exp_drop);
        chk("gsp_cycles", gsp_cyc, exp_gsp);
        if (exp_drop) chk("gck_quiet", gck_chg, 0);
        else          chk("gck_rises", gck_rise, exp_rise);
        chk("bck_toggles", bck_tog, exp_bck);
        chk("bsp_pulses", bsp_rise, exp_drop ? 0 : 1);
        chk("gen_cycles", {gen_rise, gen_cyc}, {exp_drop ? 0 : 1, exp_gen});
        chk("line", o_line, exp_ln);
        chk("bck_idle_low", o_bck, 0);
        chk("rinc_rules", {rinc_empty, rinc_consec}, 64'd0);
        bad = 0;
        for (int i = 0; i < rgb_seen.size() && i < BPL; i++)
            if (rgb_seen[i] !== px[i][5:0]) bad++;
        chk("rgb_data", bad, 0);
    endtask

    initial begin
        int guard;
        logic [25:0] rv_exp;
        rv_exp = 26'h0001000;
        clear_stats();
        defer_hits = 0;
        rst = 1'b1;
        tick(3);
        chk("reset_outputs", {o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_rgb, o_vcom, o_va, o_vb,
                              o_busy, o_line, o_drop, fifo_if.o_rinc}, rv_exp);
        rst = 1'b0;
        tick(1);
        chk("intb_up", o_intb, 1);

        run_packet(0, 8'h2A, 0);
        run_packet(5, -1, 0);
        run_packet(2, -1, 0);
        run_packet(200, -1, 0);
        run_packet(2, -1, 0);
        run_packet(3, -1, 1);
        for (int k = 0; k < 5; k++) run_packet($urandom_range(0, 170), -1, 0);
        chk("vcom_defer_seen", defer_hits > 0, 1);

        clear_stats();
        fq.push_back(8'd40);
        for (int i = 0; i < BPL; i++) fq.push_back(8'($urandom));
        guard = 0;
        while (bck_tog < 5 && guard < 6000) begin tick(1); guard++; end
        chk("midload_reach", guard < 6000, 1);
        rst = 1'b1;
        tick(1);
        chk("midload_reset", {o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_rgb, o_vcom, o_va, o_vb,
                              o_busy, o_line, o_drop, fifo_if.o_rinc}, rv_exp);
        fq.delete();
        tick(1);
        rst = 1'b0;
        m_valid = 0;
        m_line = 0;
        tick(2);
        run_packet(3, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memlcd_line_ctrl.md
Name: memlcd_line_ctrl

Overview:
Parametrised memory-LCD panel controller; successor to the fixed-geometry FSM and VCOM divider behind the SPI receiver and sync FIFO. Consumes line packets from the FIFO (first-word-fall-through read side) and drives gate/source timing plus VCOM/VA/VB. New relative to the previous generation:
- configurable panel geometry and timing;
- partial-frame update: only addressed lines are written, with gate skip;
- bad-packet drop;
- VCOM toggle deferral during GEN.

Parameters:
H_PIXELS, 72, pixels per line (even); BYTES_PER_LINE = H_PIXELS/2
V_LINES, 144, gate lines (<=255)
BCK_HALF, 4, i_clk cycles per BCK half-period (>=2)
GCK_HALF, 8, i_clk cycles per GCK half-period (>=2)
GEN_CYCLES, 16, i_clk cycles GEN held high per line write
VCOM_DIV, 833333, i_clk cycles per VCOM half-period (60 Hz at 100 MHz)
VCOM_SYNC, 1, 1 = defer VCOM toggle while GEN high

Ports:
i_clk  in  1  system clock, 100 MHz
i_reset  in  1  reset
i_data  in  8  FIFO head byte, valid when i_rempty low
i_rempty  in  1  FIFO empty
o_rinc  out  1  FIFO pop, one cycle per byte consumed
o_intb  out  1  panel init enable
o_gsp, o_gck, o_gen  out  1 each  gate start pulse, gate clock, gate enable
o_bsp, o_bck  out  1 each  source start pulse, source clock
o_rgb  out  6  two pixels × RGB; bits [5:3] first pixel
o_vcom, o_va, o_vb  out  1 each  VCOM; VA = ~VCOM; VB = VCOM
o_busy  out  1  high whenever state is not IDLE
o_line  out  8  current gate position
o_drop  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Clocking and reset:
  - Single clock domain i_clk.
  - Reset is synchronous and active-high on i_reset.
  - All outputs reset to 0 except o_va = 1.
  - State returns to IDLE, counters clear, gate position invalid.
  - Reset mid-packet: the remainder of the packet is not consumed. The host must flush the FIFO.
- o_intb goes 1 on the first cycle after reset deasserts and stays 1.
- Packet format: 1 address byte (0..V_LINES-1), then BYTES_PER_LINE pixel bytes. Pixel byte bits [5:0] drive o_rgb; bits [7:6] are ignored.
- o_rinc rules:
  - Asserted only when i_rempty = 0.
  - Never asserted in two consecutive cycles.
  - The byte is sampled on the same cycle o_rinc is high.
- States:
  - IDLE: on i_rempty = 0, pop the header.
    - addr >= V_LINES → DROP and pulse o_drop.
    - Gate position invalid, or addr < o_line → GSTART.
    - Otherwise → SEEK.
  - DROP: pop BYTES_PER_LINE bytes, stalling while empty; then → IDLE. No panel pins toggle.
  - GSTART: o_gsp = 1 for GCK_HALF cycles; o_line = 0; gate valid; → SEEK.
  - SEEK: while o_line != addr, toggle o_gck every GCK_HALF cycles; o_line increments on each rising edge of o_gck. When equal → LOAD.
  - LOAD: o_bsp = 1 for the first BCK half-period. Per byte:
    - wait for !i_rempty;
    - pop the byte and register it onto o_rgb;
    - hold BCK_HALF cycles;
    - toggle o_bck.
    - On an empty stall, o_bck and o_rgb hold their values.
    - After BYTES_PER_LINE toggles, o_bck returns to 0 (extra cycle if needed) → WRITE.
  - WRITE: o_gen = 1 for exactly GEN_CYCLES cycles, then 0 → IDLE. Gate stays at o_line.
- o_gck level persists between packets. GSTART forces o_gck = 0 first.
- VCOM:
  - Free-running counter 0..VCOM_DIV-1; toggles o_vcom at wrap.
  - If VCOM_SYNC = 1 and o_gen = 1 at wrap, the toggle is deferred to the first cycle o_gen = 0. The counter keeps running.
  - VCOM runs independently of packet state.
- Address == o_line (gate already there): SEEK completes in 0 cycles; line is rewritten.
- Latency, header pop → first o_rgb update (FIFO non-empty, gate valid, addr = o_line + 1): ≤ 2·GCK_HALF + 2 cycles.

Test Plan:
- Reset then header 0x00 + 36 bytes 0x2A (defaults): GSP high 8 cycles; o_bck 36 toggles, o_rgb = 0x2A; o_gen high exactly 16 cycles; o_rinc count = 37; o_line = 0.
- Packets addr 5 then addr 2: 5 o_gck rising edges to line 5; second packet re-issues GSP and 2 rising edges; o_line = 2.
- Header 0xC8 (200 ≥ 144) + 36 bytes: o_drop one pulse; 37 pops; no gsp/gck/bck/gen activity; o_busy back to 0.
- FIFO empties after 10 pixel bytes for 50 cycles: o_bck and o_rgb frozen; o_rinc never asserted while i_rempty = 1; line completes normally after refill.
- VCOM_DIV = 20, VCOM_SYNC = 1: VCOM wrap lands during o_gen high → toggle on the first cycle after o_gen falls; o_va = ~o_vcom throughout.
- Assert i_reset mid-LOAD: next cycle all outputs 0 (o_va = 1), o_busy = 0. Flush, then packet addr 3: GSTART is issued (gate invalid).
